// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the seq_fsm sequencer.
// Contents: the 2-bit state enum (IDLE/GO/DONE) and the encoding constants,
//           including the one unused encoding that the FSM recovers from.
package seq_fsm_pkg;

   localparam logic [1:0] ST_ENC_IDLE    = 2'd0;
   localparam logic [1:0] ST_ENC_GO      = 2'd1;
   localparam logic [1:0] ST_ENC_DONE    = 2'd2;
   localparam logic [1:0] ST_ENC_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = ST_ENC_IDLE,
      ST_GO   = ST_ENC_GO,
      ST_DONE = ST_ENC_DONE
   } state_e;

endpackage

// File: rtl/seq_cnt.sv
// Purpose : GO-phase down-counter with load (len-1, floored at 0), decrement-if-nonzero and clear.
// Latency : all operations take effect at the next rising clk edge; o_zero is combinational from the register.
// Backpress: none; the counter acts on whatever the FSM commands each cycle.
// Ports   : clk, rst_n (async active-low), i_clr > i_load > i_dec priority,
//           i_load_val (raw length), o_cnt (current value), o_zero (o_cnt == 0).
module seq_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         // A length of 0 still yields one GO cycle, so it loads like length 1.
         r_cnt <= (i_load_val == '0) ? '0 : (i_load_val - ONE);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - ONE;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_fsm.sv
// Purpose : IDLE -> GO (max(len,1) cycles) -> DONE (1 cycle) sequencer with Moore-decoded outputs.
// Latency : start sampled at edge t gives GO from t+1; DONE follows the last GO cycle; start in DONE reloads directly.
// Backpress: none; start is only looked at in IDLE and DONE, ignored while GO runs.
// Ports   : clk, rst_n (async active-low), start, len[CNT_W] in; ctl, done, busy, state[2], cnt[CNT_W] out.
// Option  : define SEQ_FSM_ABORT_EN to add input abort and output aborted (early GO termination).
module seq_fsm
   import seq_fsm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
`ifdef SEQ_FSM_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             ctl,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cnt
);

   state_e           r_state;
   state_e           w_nxt;
   logic             w_load;
   logic             w_clr;
   logic             w_dec;
   logic             w_zero;
   logic [CNT_W-1:0] w_cnt;

`ifdef SEQ_FSM_ABORT_EN
   logic             w_abort_hit;
   logic             r_aborted;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_comb begin
      w_nxt  = ST_IDLE;
      w_load = 1'b0;
      w_clr  = 1'b0;
      w_dec  = 1'b0;
`ifdef SEQ_FSM_ABORT_EN
      w_abort_hit = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_nxt  = ST_GO;
               w_load = 1'b1;
            end else begin
               w_nxt = ST_IDLE;
               w_clr = 1'b1;
            end
         end
         ST_GO: begin
`ifdef SEQ_FSM_ABORT_EN
            if (abort) begin
               // Abort wins even when the count has already reached 0.
               w_nxt       = ST_DONE;
               w_clr       = 1'b1;
               w_abort_hit = 1'b1;
            end else
`endif
            if (w_zero) begin
               w_nxt = ST_DONE;
            end else begin
               w_nxt = ST_GO;
               w_dec = 1'b1;
            end
         end
         ST_DONE: begin
            // Back-to-back: a start here skips IDLE entirely.
            if (start) begin
               w_nxt  = ST_GO;
               w_load = 1'b1;
            end else begin
               w_nxt = ST_IDLE;
               w_clr = 1'b1;
            end
         end
         default: begin
            // Unused encoding: recover to IDLE and scrub the count.
            w_nxt = ST_IDLE;
            w_clr = 1'b1;
         end
      endcase
   end

   seq_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr),
      .i_load     (w_load),
      .i_load_val (len),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

`ifdef SEQ_FSM_ABORT_EN
   // Flag lives only for the DONE cycle that the abort produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aborted <= 1'b0;
      end else begin
         r_aborted <= w_abort_hit;
      end
   end

   assign aborted = r_aborted;
`endif

   assign ctl   = (r_state == ST_GO);
   assign done  = (r_state == ST_DONE);
   assign busy  = (r_state != ST_IDLE);
   assign state = r_state;
   assign cnt   = w_cnt;

endmodule

// File: doc/seq_fsm.md
SEQ_FSM -- requirements
Module: seq_fsm

Interface
REQ-001 Parameter CNT_W, default 8: width of the GO-phase length and down-counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a sequence; sampled in IDLE and DONE only.
REQ-005 len  input  CNT_W  GO-phase length in cycles; sampled with start.
REQ-006 abort  input  1  terminate GO phase early; present only with SEQ_FSM_ABORT_EN.
REQ-007 ctl  output  1  high while in GO.
REQ-008 done  output  1  high for the single DONE cycle.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 state  output  2  current state encoding.
REQ-011 cnt  output  CNT_W  remaining GO cycles minus one; 0 outside GO.
REQ-012 aborted  output  1  high in a DONE cycle reached via abort; present only with SEQ_FSM_ABORT_EN.

Function
REQ-013 States SHALL be IDLE=0, GO=1, DONE=2; encoding 3 is illegal.
REQ-014 Outputs SHALL be Moore decodes: ctl=(state==GO), done=(state==DONE), busy=(state!=IDLE).
REQ-015 IDLE, start=1 at edge t: state=GO from t+1; cnt loaded with len-1, or 0 when len==0.
REQ-016 IDLE, start=0: remain IDLE, cnt held at 0.
REQ-017 GO, cnt!=0: cnt decrements by 1 per cycle; start and len ignored.
REQ-018 GO, cnt==0: next state DONE; cnt stays 0.
REQ-019 GO lasts exactly max(len,1) cycles; len=2^CNT_W-1 gives 2^CNT_W-1 cycles with no wrap.
REQ-020 DONE lasts exactly one cycle; start=1 in DONE goes directly to GO with len reloaded (back-to-back, no IDLE cycle); otherwise next state IDLE.
REQ-021 Illegal state 3: outputs ctl=0, done=0, busy=1; next state IDLE, cnt cleared.
REQ-022 cnt output SHALL never underflow; decrement only when nonzero.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, cnt=0, hence ctl=0, done=0, busy=0 (and aborted=0).
REQ-024 Reset asserted mid-GO or mid-DONE SHALL abandon the sequence; no DONE pulse is produced.
REQ-025 After deassertion, the first start sampled SHALL behave per REQ-015.

Configuration
REQ-026 Macro SEQ_FSM_ABORT_EN: when defined, ports abort and aborted exist; abort=1 in GO forces next state DONE, cnt cleared, aborted=1 during that DONE cycle; abort outside GO ignored.
REQ-027 When SEQ_FSM_ABORT_EN is undefined, ports abort and aborted are absent and GO always runs its full length.
REQ-028 abort and cnt==0 in the same GO cycle: DONE with aborted=1.

Structure
REQ-029 State enum typedef (2-bit, IDLE/GO/DONE) and state-encoding constants SHALL live in shared package seq_fsm_pkg.
REQ-030 Down-counter (load, decrement-if-nonzero, clear) SHALL be sub-module seq_cnt, parametrised by CNT_W; the FSM is in seq_fsm.

Verification
REQ-031 Reset then start=1 for one cycle with len=5 -> ctl high exactly cycles t+1..t+5, done high at t+6, busy low at t+7.
REQ-032 len=0 with start -> single GO cycle, then DONE; len=255 (CNT_W=8) -> 255 GO cycles, cnt 254 down to 0.
REQ-033 start held high, len=3 -> repeating GO x3, DONE x1 pattern, never IDLE.
REQ-034 rst_n pulsed low at 2nd GO cycle of len=10 run -> immediate IDLE, all outputs 0, no done pulse.
REQ-035 With SEQ_FSM_ABORT_EN, len=8, abort at 3rd GO cycle -> DONE next cycle with aborted=1; abort in IDLE -> no effect.
REQ-036 Force state=3 -> next cycle IDLE, ctl=0, cnt=0.
